// File: rtl/riscv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : riscv_pkg
// Description : Shared fetch-path definitions. These are the data width, the
//               canonical NOP encoding, the PC increment and the encoding of
//               the fetch FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_pkg;

   localparam int unsigned XLEN = 32;

   // ADDI x0, x0, 0
   localparam logic [XLEN-1:0] INSTR_NOP = 32'h0000_0013;

   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      HOLD = 2'd3
   } fetch_state_e;

endpackage : riscv_pkg
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Instruction-memory request/response bus between the fetch
//               unit (master) and the instruction memory (slave).
//   imem_req_o    : request valid (master -> slave)
//   imem_addr_o   : request address (master -> slave)
//   imem_gnt_i    : request accepted this cycle (slave -> master)
//   imem_rvalid_i : read data valid (slave -> master)
//   imem_rdata_i  : instruction word (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if;
   import riscv_pkg::*;

   logic            imem_req_o;
   logic [XLEN-1:0] imem_addr_o;
   logic            imem_gnt_i;
   logic            imem_rvalid_i;
   logic [XLEN-1:0] imem_rdata_i;

   modport master (
      output imem_req_o,
      output imem_addr_o,
      input  imem_gnt_i,
      input  imem_rvalid_i,
      input  imem_rdata_i
   );

   modport slave (
      input  imem_req_o,
      input  imem_addr_o,
      output imem_gnt_i,
      output imem_rvalid_i,
      output imem_rdata_i
   );

endinterface : instr_fetch_unit_if
`default_nettype wire

// File: rtl/fetch_skid_buffer.sv
`default_nettype none
// ============================================================================
// Module      : fetch_skid_buffer
// Description : Single-entry PC + instruction holding register with a valid
//               flag. It parks a returned instruction while the IF/ID stage
//               is stalled. Clear has priority over load.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : capture wr_pc / wr_instr and mark the entry valid
//   clear           : drop the entry
//   wr_pc, wr_instr : data to capture
//   valid, pc, instr: stored entry
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_skid_buffer
   import riscv_pkg::*;
(
   input  wire logic            clk,
   input  wire logic            rst_n,
   input  wire logic            load,
   input  wire logic            clear,
   input  wire logic [XLEN-1:0] wr_pc,
   input  wire logic [XLEN-1:0] wr_instr,
   output logic                 valid,
   output logic [XLEN-1:0]      pc,
   output logic [XLEN-1:0]      instr
);

   logic            r_valid;
   logic [XLEN-1:0] r_pc;
   logic [XLEN-1:0] r_instr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_pc    <= '0;
         r_instr <= INSTR_NOP;
      end else if (clear) begin
         r_valid <= 1'b0;
      end else if (load) begin
         r_valid <= 1'b1;
         r_pc    <= wr_pc;
         r_instr <= wr_instr;
      end
   end

   assign valid = r_valid;
   assign pc    = r_pc;
   assign instr = r_instr;

endmodule : fetch_skid_buffer
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Instruction fetch stage. It issues one instruction-memory
//               request at a time and fills the IF/ID register. A one-entry
//               skid buffer absorbs a response that returns during a decode
//               stall. Branch redirects flush the stage, and a response
//               still in flight for the old path is squashed.
//   clk_i, rst_ni   : clock, asynchronous active-low reset
//   PCSrc_i         : redirect request (branch taken)
//   branch_target_i : redirect address (low two bits ignored)
//   stall_i         : decode cannot accept; IF/ID holds
//   imem            : instruction-memory bus (master side)
//   if_valid_o      : IF/ID register holds a valid instruction
//   if_pc_o         : PC of the held instruction
//   if_instr_o      : held instruction
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
)(
   input  wire logic            clk_i,
   input  wire logic            rst_ni,
   input  wire logic            PCSrc_i,
   input  wire logic [XLEN-1:0] branch_target_i,
   input  wire logic            stall_i,
   instr_fetch_unit_if.master   imem,
   output logic                 if_valid_o,
   output logic [XLEN-1:0]      if_pc_o,
   output logic [XLEN-1:0]      if_instr_o
);

   fetch_state_e    r_state;
   logic [XLEN-1:0] r_pc;
   logic            r_squash;
   logic            r_req;
   logic            r_if_valid;
   logic [XLEN-1:0] r_if_pc;
   logic [XLEN-1:0] r_if_instr;

   logic [XLEN-1:0] w_target;
   logic [XLEN-1:0] w_pc_next;
   logic            w_out_free;
   logic            w_redirect_inflight;
   logic            w_skid_load;
   logic            w_skid_clear;
   logic            w_skid_valid;
   logic [XLEN-1:0] w_skid_pc;
   logic [XLEN-1:0] w_skid_instr;
   logic            w_unused_tgt;

   // Targets are always word aligned, so the low bits are forced to zero.
   assign w_target     = {branch_target_i[XLEN-1:2], 2'b00};
   assign w_unused_tgt = ^branch_target_i[1:0];

   // This addition wraps naturally at 32 bits.
   assign w_pc_next  = r_pc + PC_INC;
   assign w_out_free = !r_if_valid || !stall_i;

   // A redirect leaves a request in flight when it arrives in WAIT without
   // the response, or in the same cycle a request is granted. That response
   // belongs to the old path and has to be squashed when it returns.
   assign w_redirect_inflight = ((r_state == WAIT) && !imem.imem_rvalid_i) ||
                                ((r_state == REQ)  &&  imem.imem_gnt_i);

   assign w_skid_load  = !PCSrc_i && (r_state == WAIT) && imem.imem_rvalid_i &&
                         !r_squash && !w_out_free;
   assign w_skid_clear = PCSrc_i || ((r_state == HOLD) && !stall_i);

   fetch_skid_buffer u_skid (
      .clk      (clk_i),
      .rst_n    (rst_ni),
      .load     (w_skid_load),
      .clear    (w_skid_clear),
      .wr_pc    (r_pc),
      .wr_instr (imem.imem_rdata_i),
      .valid    (w_skid_valid),
      .pc       (w_skid_pc),
      .instr    (w_skid_instr)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= IDLE;
         r_pc       <= RESET_PC;
         r_squash   <= 1'b0;
         r_req      <= 1'b0;
         r_if_valid <= 1'b0;
         r_if_pc    <= '0;
         r_if_instr <= INSTR_NOP;
      end else if (PCSrc_i) begin
         // A redirect wins over a stall. The IF/ID stage is flushed in both cases.
         r_pc       <= w_target;
         r_if_valid <= 1'b0;
         if (w_redirect_inflight) begin
            r_state  <= WAIT;
            r_squash <= 1'b1;
            r_req    <= 1'b0;
         end else begin
            r_state  <= REQ;
            r_squash <= 1'b0;
            r_req    <= 1'b1;
         end
      end else begin
         // Decode took the held instruction. A load below overrides this.
         if (r_if_valid && !stall_i) begin
            r_if_valid <= 1'b0;
         end
         case (r_state)
            IDLE: begin
               r_state <= REQ;
               r_req   <= 1'b1;
            end
            REQ: begin
               if (imem.imem_gnt_i) begin
                  r_state <= WAIT;
                  r_req   <= 1'b0;
               end
            end
            WAIT: begin
               if (imem.imem_rvalid_i) begin
                  if (r_squash) begin
                     // Stale response from before the redirect. Drop it.
                     r_squash <= 1'b0;
                     r_state  <= REQ;
                     r_req    <= 1'b1;
                  end else if (w_out_free) begin
                     r_if_valid <= 1'b1;
                     r_if_pc    <= r_pc;
                     r_if_instr <= imem.imem_rdata_i;
                     r_pc       <= w_pc_next;
                     r_state    <= REQ;
                     r_req      <= 1'b1;
                  end else begin
                     // The skid buffer captures the response. See w_skid_load.
                     r_pc    <= w_pc_next;
                     r_state <= HOLD;
                     r_req   <= 1'b0;
                  end
               end
            end
            HOLD: begin
               if (!stall_i) begin
                  r_if_valid <= w_skid_valid;
                  r_if_pc    <= w_skid_pc;
                  r_if_instr <= w_skid_instr;
                  r_state    <= REQ;
                  r_req      <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_req   <= 1'b0;
            end
         endcase
      end
   end

   assign imem.imem_req_o  = r_req;
   assign imem.imem_addr_o = r_pc;
   assign if_valid_o       = r_if_valid;
   assign if_pc_o          = r_if_pc;
   assign if_instr_o       = r_if_instr;

endmodule : instr_fetch_unit
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. A second
//               instance with RESET_PC = 32'hFFFF_FFFC exercises PC wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pcsrc = 1'b0;
   logic [31:0] target = '0;
   logic        stall = 1'b0;
   logic        if_valid;
   logic [31:0] if_pc;
   logic [31:0] if_instr;

   logic        pcsrc2 = 1'b0;
   logic [31:0] target2 = '0;
   logic        stall2 = 1'b0;
   logic        if_valid2;
   logic [31:0] if_pc2;
   logic [31:0] if_instr2;

   int errors = 0;
   int checks = 0;

   // Memory model state: one outstanding granted request
   bit          pend = 1'b0;
   logic [31:0] pend_addr = '0;

   instr_fetch_unit_if bus ();
   instr_fetch_unit_if bus2 ();

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .PCSrc_i         (pcsrc),
      .branch_target_i (target),
      .stall_i         (stall),
      .imem            (bus.master),
      .if_valid_o      (if_valid),
      .if_pc_o         (if_pc),
      .if_instr_o      (if_instr)
   );

   instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .PCSrc_i         (pcsrc2),
      .branch_target_i (target2),
      .stall_i         (stall2),
      .imem            (bus2.master),
      .if_valid_o      (if_valid2),
      .if_pc_o         (if_pc2),
      .if_instr_o      (if_instr2)
   );

   // One clock cycle of the memory model. gnt follows req when allowed. A
   // granted request returns 32'h1000_0000 | addr on the next cycle in which
   // rvalid is allowed.
   task automatic cyc(input bit allow_gnt, input bit allow_rv);
      logic        g;
      logic [31:0] a;
      bus.imem_rvalid_i = pend & allow_rv;
      bus.imem_rdata_i  = (pend & allow_rv) ? (32'h1000_0000 | pend_addr) : 32'hDEAD_BEEF;
      bus.imem_gnt_i    = bus.imem_req_o & allow_gnt;
      g = bus.imem_gnt_i;
      a = bus.imem_addr_o;
      @(posedge clk);
      #1;
      pend      = g | (pend & ~allow_rv);
      pend_addr = g ? a : pend_addr;
   endtask

   task automatic test_reset();
      bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = '0;
      bus2.imem_gnt_i = 1'b0; bus2.imem_rvalid_i = 1'b0; bus2.imem_rdata_i = '0;
      pend = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.imem_req_o); end
      checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 00000000", bus.imem_addr_o); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", if_valid); end
      checks++; if (if_pc !== 32'h0) begin errors++; $display("FAIL rst_pc: got %h want 00000000", if_pc); end
      checks++; if (if_instr !== 32'h0000_0013) begin errors++; $display("FAIL rst_instr: got %h want 00000013", if_instr); end
   endtask

   task automatic test_sequential();
      logic [31:0] exp_pc;
      cyc(1'b1, 1'b1); // IDLE -> REQ
      for (int k = 0; k < 3; k++) begin
         exp_pc = 32'(k) * 32'd4;
         checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== exp_pc) begin errors++; $display("FAIL seq_req%0d: got req=%b addr=%h want req=1 addr=%h", k, bus.imem_req_o, bus.imem_addr_o, exp_pc); end
         cyc(1'b1, 1'b1); // grant
         checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL seq_drain%0d: got valid=%b want 0", k, if_valid); end
         cyc(1'b1, 1'b1); // rvalid
         checks++; if (if_valid !== 1'b1 || if_pc !== exp_pc || if_instr !== (32'h1000_0000 | exp_pc)) begin errors++; $display("FAIL seq_out%0d: got v=%b pc=%h instr=%h want v=1 pc=%h instr=%h", k, if_valid, if_pc, if_instr, exp_pc, 32'h1000_0000 | exp_pc); end
      end
      checks++; if (bus.imem_addr_o !== 32'hC) begin errors++; $display("FAIL seq_next_addr: got %h want 0000000c", bus.imem_addr_o); end
   endtask

   task automatic test_stall_skid();
      stall = 1'b1;
      cyc(1'b1, 1'b1); // grant for 0xC
      cyc(1'b1, 1'b1); // response for 0xC arrives while stalled
      checks++; if (bus.imem_req_o !== 1'b0 || if_valid !== 1'b1 || if_pc !== 32'h8 || if_instr !== 32'h1000_0008) begin errors++; $display("FAIL stall_hold: got req=%b v=%b pc=%h instr=%h want req=0 v=1 pc=00000008 instr=10000008", bus.imem_req_o, if_valid, if_pc, if_instr); end
      cyc(1'b1, 1'b1);
      checks++; if (bus.imem_req_o !== 1'b0 || if_pc !== 32'h8 || if_instr !== 32'h1000_0008) begin errors++; $display("FAIL stall_hold2: got req=%b pc=%h instr=%h want req=0 pc=00000008 instr=10000008", bus.imem_req_o, if_pc, if_instr); end
      stall = 1'b0;
      cyc(1'b1, 1'b1); // skid -> IF/ID
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'hC || if_instr !== 32'h1000_000C) begin errors++; $display("FAIL skid_out: got v=%b pc=%h instr=%h want v=1 pc=0000000c instr=1000000c", if_valid, if_pc, if_instr); end
      checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h10) begin errors++; $display("FAIL skid_next_req: got req=%b addr=%h want req=1 addr=00000010", bus.imem_req_o, bus.imem_addr_o); end
      cyc(1'b1, 1'b1);
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL skid_nodup: got v=%b want 0", if_valid); end
      cyc(1'b1, 1'b1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h10) begin errors++; $display("FAIL skid_after: got v=%b pc=%h want v=1 pc=00000010", if_valid, if_pc); end
   endtask

   task automatic test_redirect_wait();
      cyc(1'b1, 1'b1); // grant for 0x14, now in WAIT
      pcsrc = 1'b1; target = 32'h100;
      cyc(1'b1, 1'b0); // redirect while the response is still outstanding
      pcsrc = 1'b0;
      checks++; if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h100 || if_valid !== 1'b0) begin errors++; $display("FAIL redir_wait: got req=%b addr=%h v=%b want req=0 addr=00000100 v=0", bus.imem_req_o, bus.imem_addr_o, if_valid); end
      cyc(1'b1, 1'b1); // stale response for 0x14 returns
      checks++; if (if_valid !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin errors++; $display("FAIL redir_squash: got v=%b req=%b addr=%h want v=0 req=1 addr=00000100", if_valid, bus.imem_req_o, bus.imem_addr_o); end
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h100 || if_instr !== 32'h1000_0100) begin errors++; $display("FAIL redir_out: got v=%b pc=%h instr=%h want v=1 pc=00000100 instr=10000100", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_redirect_stall();
      stall = 1'b1; pcsrc = 1'b1; target = 32'h203;
      cyc(1'b0, 1'b0);
      pcsrc = 1'b0; stall = 1'b0;
      checks++; if (bus.imem_addr_o !== 32'h200 || if_valid !== 1'b0 || bus.imem_req_o !== 1'b1) begin errors++; $display("FAIL redir_stall: got addr=%h v=%b req=%b want addr=00000200 v=0 req=1", bus.imem_addr_o, if_valid, bus.imem_req_o); end
      cyc(1'b1, 1'b1);
      cyc(1'b1, 1'b1);
      checks++; if (if_valid !== 1'b1 || if_pc !== 32'h200 || if_instr !== 32'h1000_0200) begin errors++; $display("FAIL redir_stall_out: got v=%b pc=%h instr=%h want v=1 pc=00000200 instr=10000200", if_valid, if_pc, if_instr); end
   endtask

   task automatic test_reset_mid();
      cyc(1'b1, 1'b1); // grant for 0x204, now in WAIT
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_req_o !== 1'b0 || bus.imem_addr_o !== 32'h0 || if_valid !== 1'b0 || if_instr !== 32'h0000_0013) begin errors++; $display("FAIL mid_rst: got req=%b addr=%h v=%b instr=%h want req=0 addr=00000000 v=0 instr=00000013", bus.imem_req_o, bus.imem_addr_o, if_valid, if_instr); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1'b0, 1'b1); // late rvalid from before reset
      checks++; if (if_valid !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL late_rvalid: got v=%b req=%b addr=%h want v=0 req=1 addr=00000000", if_valid, bus.imem_req_o, bus.imem_addr_o); end
   endtask

   task automatic test_wrap();
      checks++; if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_first: got req=%b addr=%h want req=1 addr=fffffffc", bus2.imem_req_o, bus2.imem_addr_o); end
      bus2.imem_gnt_i = 1'b1;
      cyc(1'b0, 1'b0);
      bus2.imem_gnt_i = 1'b0; bus2.imem_rvalid_i = 1'b1; bus2.imem_rdata_i = 32'h1234_5678;
      cyc(1'b0, 1'b0);
      bus2.imem_rvalid_i = 1'b0;
      checks++; if (if_valid2 !== 1'b1 || if_pc2 !== 32'hFFFF_FFFC || if_instr2 !== 32'h1234_5678) begin errors++; $display("FAIL wrap_out: got v=%b pc=%h instr=%h want v=1 pc=fffffffc instr=12345678", if_valid2, if_pc2, if_instr2); end
      checks++; if (bus2.imem_req_o !== 1'b1 || bus2.imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_second: got req=%b addr=%h want req=1 addr=00000000", bus2.imem_req_o, bus2.imem_addr_o); end
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall_skid();
      test_redirect_wait();
      test_redirect_stall();
      test_reset_mid();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule : tb_instr_fetch_unit
`default_nettype wire
